rv32i_instr_encoder: RTL and testbench
======================================

Name: rv32i_instr_encoder

Overview:
Packs RV32I instruction fields into 32-bit instruction words in the R/I/S/SB/U/UJ formats. This is the inverse of the decode-side instruction types. It feeds the debug program buffer and self-test stimulus paths. It has a 2-stage pipeline (encode register followed by an output FIFO) with valid/ready on both sides, legality checking, and error reporting.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; power of 2, >=2
ERR_CNT_W, 8, width of saturating error counter

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
flush  in  1  synchronous clear of stage register and FIFO
in_valid  in  1  field bundle valid
in_ready  out  1  bundle accepted when in_valid & in_ready
opcode  in  7  opcode field
funct3  in  3  funct3 field
funct7  in  7  funct7 field (R-type, shift-immediates)
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
imm  in  32  signed byte-offset/immediate, unscaled
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer pops when out_valid & out_ready
out_instr  out  32  FIFO head instruction word
err_pulse  out  1  one-cycle pulse when an illegal bundle retires
err_cause  out  2  last error cause: 01 opcode, 10 funct3/funct7, 11 immediate range
err_count  out  ERR_CNT_W  saturating illegal-bundle count
fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (nRST=0 at edge): stage empty, FIFO empty, out_valid=0, out_instr=0, err_pulse=0, err_cause=00, err_count=0, fifo_count=0. Reset mid-operation discards all contents.
- Format select by opcode:
  - LUI/AUIPC: U, [31:12]=imm[31:12].
  - JAL: UJ, [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - JALR/LOAD/IMMED: I, [31:20]=imm[11:0]. SLLI/SRI use [31:25]=funct7, [24:20]=imm[4:0].
  - STORE: S, [31:25]=imm[11:5], [11:7]=imm[4:0].
  - BRANCH: SB, [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - REGREG: R.
  - Fields not used by a format are ignored.
- Legality:
  - Cause 01: opcode not one of the 9 base opcodes.
  - Cause 10:
    - JALR funct3!=000.
    - BRANCH funct3 010/011.
    - LOAD funct3 011/110/111.
    - STORE funct3>010.
    - SLLI funct7!=0.
    - SRI funct7 not 0000000/0100000.
    - REGREG: funct7=0100000 is legal only for ADDSUB/SR; every other funct7!=0 is illegal.
- Stage: an accepted bundle is encoded combinationally and registered with its legal flag and cause at the accept edge.
  - Next edge, a legal stage entry pushes to the FIFO if it has space (count<FIFO_DEPTH, or a pop occurs that same cycle).
  - An illegal stage entry always retires: no push; err_pulse=1 for that cycle; err_cause updated; err_count++ (holds at all-ones).
- in_ready = !flush & (stage empty | stage retiring this cycle). Throughput is 1 bundle/cycle with no bubbles.
- Latency: accept at edge N; out_valid visible after edge N+1 (FIFO was empty).
- FIFO order is strict. Simultaneous push and pop at full or empty is legal; count is unchanged.
- flush=1 at an edge empties the stage and FIFO. A stage entry present at that edge is dropped without error. err_count and err_cause are kept. flush has lower priority than nRST.

Optional Feature:
RV32I_ENC_IMM_CHECK_EN
- Defined: out-of-range immediates are treated as illegal with cause 11 (retire, no push). The rules are:
  - I/S: imm in [-2048,2047].
  - SB: imm in [-4096,4094] and even.
  - UJ: imm in [-2^20,2^20-2] and even.
  - U: imm[11:0]=0.
  - Shifts: imm[31:5]=0.
- Undefined: out-of-range bits are silently truncated, and cause 11 never occurs.

Test Plan:
- ADDI x1,x0,5 (opcode 0010011, f3 000, rd 1, imm 5), out_ready=1 -> out_instr=0x00500093 with out_valid high after the second edge following accept.
- BEQ x1,x2,+8 -> 0x00208463; JAL x1,+2048 -> 0x001000EF; SW x2,-4(x1) -> 0xFE20AE23.
- out_ready=0, push 6 legal bundles -> 5 accepted (4 in FIFO + 1 in stage), in_ready=0, fifo_count=4; raise out_ready -> all 5 drain in order, one per cycle.
- opcode 0x7F -> no output, err_pulse 1 cycle, err_cause=01, err_count=1; then LOAD f3 011 -> cause 10, count 2; 300 illegal bundles -> err_count holds at 255.
- FIFO holding 3 words, assert flush -> next edge out_valid=0, fifo_count=0, err_count unchanged; repeat with nRST=0 -> err_count=0.
- Macro defined: ADDI imm 4096 -> err_cause=11, no output; macro undefined -> out_instr=0x00000093 for rd 1.

Source files
------------

// File: rtl/rv32i_instr_encoder_if.sv
// Field-bundle in / instruction-word out bus for the RV32I instruction encoder.
// master: producer of field bundles and consumer of instruction words.
// slave:  the encoder. fifo_count width follows FIFO_DEPTH.
interface rv32i_instr_encoder_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [4:0]           rd;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic [31:0]          imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_instr;
  logic                 err_pulse;
  logic [1:0]           err_cause;
  logic [ERR_CNT_W-1:0] err_count;
  logic [CNT_W-1:0]     fifo_count;

  modport master (
    output flush, in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_instr, err_pulse, err_cause, err_count, fifo_count
  );

  modport slave (
    input  flush, in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_instr, err_pulse, err_cause, err_count, fifo_count
  );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// Purpose: packs RV32I fields into R/I/S/SB/U/UJ words, checks legality, counts errors.
// Latency: bundle accepted at edge N is visible on out_valid after edge N+1 (empty FIFO).
// Backpressure: in_ready drops when the stage holds a legal word and the FIFO is full.
// Ports: CLK, nRST (sync, active-low); bus (slave) carries flush, the in_valid/in_ready
// field bundle, out_valid/out_ready/out_instr and the err_*/fifo_count status.
// Optional: define RV32I_ENC_IMM_CHECK_EN to flag out-of-range immediates as cause 11.
module rv32i_instr_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 8
) (
  input logic                  CLK,
  input logic                  nRST,
  rv32i_instr_encoder_if.slave bus
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // ---------------- combinational encode + legality ----------------
  logic [31:0] enc_instr;
  logic [1:0]  base_cause;
  logic [1:0]  enc_cause;
  logic        is_shift;
  logic        imm_bad;

  // funct3 001 (SLLI) and 101 (SRLI/SRAI) take the shamt layout
  assign is_shift = (bus.opcode == OP_IMM) && (bus.funct3[1:0] == 2'b01);

  always_comb begin
    enc_instr  = '0;
    base_cause = 2'b00;
    case (bus.opcode)
      OP_LUI, OP_AUIPC:
        enc_instr = {bus.imm[31:12], bus.rd, bus.opcode};
      OP_JAL:
        enc_instr = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
      OP_JALR, OP_LOAD: begin
        enc_instr = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        if (bus.opcode == OP_JALR && bus.funct3 != 3'b000) base_cause = 2'b10;
        if (bus.opcode == OP_LOAD &&
            (bus.funct3 == 3'b011 || bus.funct3[2:1] == 2'b11)) base_cause = 2'b10;
      end
      OP_IMM: begin
        if (is_shift) begin
          enc_instr = {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
          if (bus.funct3[2] == 1'b0 && bus.funct7 != 7'b0000000) base_cause = 2'b10;
          if (bus.funct3[2] == 1'b1 && bus.funct7 != 7'b0000000 &&
              bus.funct7 != 7'b0100000) base_cause = 2'b10;
        end else begin
          enc_instr = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        end
      end
      OP_STORE: begin
        enc_instr = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
        if (bus.funct3 > 3'b010) base_cause = 2'b10;
      end
      OP_BRANCH: begin
        enc_instr = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                     bus.imm[4:1], bus.imm[11], bus.opcode};
        if (bus.funct3 == 3'b010 || bus.funct3 == 3'b011) base_cause = 2'b10;
      end
      OP_REG: begin
        enc_instr = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
        // 0100000 selects SUB / SRA only
        if (bus.funct7 != 7'b0000000 &&
            !(bus.funct7 == 7'b0100000 && (bus.funct3 == 3'b000 || bus.funct3 == 3'b101)))
          base_cause = 2'b10;
      end
      default: base_cause = 2'b01;
    endcase
  end

`ifdef RV32I_ENC_IMM_CHECK_EN
  // A signed range of 2^k values fits when all bits from k-1 upward are sign copies.
  always_comb begin
    imm_bad = 1'b0;
    case (bus.opcode)
      OP_LUI, OP_AUIPC: imm_bad = |bus.imm[11:0];
      OP_JAL:           imm_bad = bus.imm[0] | ~(&bus.imm[31:20] | ~|bus.imm[31:20]);
      OP_BRANCH:        imm_bad = bus.imm[0] | ~(&bus.imm[31:12] | ~|bus.imm[31:12]);
      OP_JALR, OP_LOAD, OP_STORE:
                        imm_bad = ~(&bus.imm[31:11] | ~|bus.imm[31:11]);
      OP_IMM:           imm_bad = is_shift ? |bus.imm[31:5]
                                           : ~(&bus.imm[31:11] | ~|bus.imm[31:11]);
      default:          imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  // opcode and funct errors take precedence over a range error
  assign enc_cause = (base_cause == 2'b00 && imm_bad) ? 2'b11 : base_cause;

  // ---------------- stage register + output FIFO ----------------
  logic             stg_vld;
  logic [31:0]      stg_instr;
  logic [1:0]       stg_cause;
  logic             stg_legal;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             live;
  logic             pop;
  logic             space;
  logic             push;
  logic             retire;
  logic             err_ret;
  logic             accept;
  logic [1:0]       err_cause_q;
  logic [ERR_CNT_W-1:0] err_count_q;

  assign stg_legal = (stg_cause == 2'b00);
  assign live      = nRST & ~bus.flush;
  assign pop       = live & bus.out_valid & bus.out_ready;
  // a same-cycle pop frees a slot even when the FIFO is full
  assign space     = (cnt < CNT_W'(FIFO_DEPTH)) | pop;
  assign push      = live & stg_vld & stg_legal & space;
  assign err_ret   = live & stg_vld & ~stg_legal;
  assign retire    = stg_vld & (~stg_legal | space);
  assign accept    = bus.in_valid & bus.in_ready;

  assign bus.in_ready   = ~bus.flush & (~stg_vld | retire);
  assign bus.out_valid  = (cnt != '0);
  assign bus.out_instr  = bus.out_valid ? mem[rd_ptr] : 32'h0;
  assign bus.err_pulse  = err_ret;
  assign bus.err_cause  = err_cause_q;
  assign bus.err_count  = err_count_q;
  assign bus.fifo_count = cnt;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= stg_instr;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stg_vld     <= 1'b0;
      stg_instr   <= '0;
      stg_cause   <= 2'b00;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      err_cause_q <= 2'b00;
      err_count_q <= '0;
    end else if (bus.flush) begin
      stg_vld <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        stg_vld   <= 1'b1;
        stg_instr <= enc_instr;
        stg_cause <= enc_cause;
      end else if (retire) begin
        stg_vld <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      if (err_ret) begin
        err_cause_q <= stg_cause;
        if (err_count_q != {ERR_CNT_W{1'b1}}) err_count_q <= err_count_q + ERR_CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Bench for rv32i_instr_encoder: directed format/backpressure/error/flush steps,
// then randomized bundles scored against a rule-level reference model.
module tb_rv32i_instr_encoder;
  localparam int FD = 4;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  rv32i_instr_encoder_if #(.FIFO_DEPTH(FD), .ERR_CNT_W(EW)) bus ();
  rv32i_instr_encoder #(.FIFO_DEPTH(FD), .ERR_CNT_W(EW)) dut (.CLK(clk), .nRST(nrst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fld(input logic [31:0] u, input int lo, input int n);
    return (u >> lo) & ((32'd1 << n) - 32'd1);
  endfunction

  // Reference encoding built field by field from the instruction-format tables.
  function automatic logic [31:0] ref_enc(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] base;
    base = (32'(rs1) << 15) + (32'(f3) << 12) + 32'(op);
    case (op)
      7'h37, 7'h17: return (imm & 32'hFFFFF000) + (32'(rd) << 7) + 32'(op);
      7'h6F: return (fld(imm, 20, 1) << 31) + (fld(imm, 1, 10) << 21) + (fld(imm, 11, 1) << 20)
                  + (fld(imm, 12, 8) << 12) + (32'(rd) << 7) + 32'(op);
      7'h67, 7'h03: return (fld(imm, 0, 12) << 20) + base + (32'(rd) << 7);
      7'h13: if (f3 == 3'd1 || f3 == 3'd5)
               return (32'(f7) << 25) + (fld(imm, 0, 5) << 20) + base + (32'(rd) << 7);
             else
               return (fld(imm, 0, 12) << 20) + base + (32'(rd) << 7);
      7'h23: return (fld(imm, 5, 7) << 25) + (32'(rs2) << 20) + base + (fld(imm, 0, 5) << 7);
      7'h63: return (fld(imm, 12, 1) << 31) + (fld(imm, 5, 6) << 25) + (32'(rs2) << 20) + base
                  + (fld(imm, 1, 4) << 8) + (fld(imm, 11, 1) << 7);
      7'h33: return (32'(f7) << 25) + (32'(rs2) << 20) + base + (32'(rd) << 7);
      default: return 32'h0;
    endcase
  endfunction

  // 0 = legal, otherwise the error cause the encoder must report.
  function automatic int ref_cause(input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    bit known;
    int s;
    known = 0;
    foreach (ops[k]) if (ops[k] == op) known = 1;
    s = $signed(imm);
    if (!known) return 1;
    if (op == 7'h67 && f3 != 0) return 2;
    if (op == 7'h63 && (f3 == 2 || f3 == 3)) return 2;
    if (op == 7'h03 && (f3 == 3 || f3 >= 6)) return 2;
    if (op == 7'h23 && f3 > 2) return 2;
    if (op == 7'h13 && f3 == 1 && f7 != 0) return 2;
    if (op == 7'h13 && f3 == 5 && !(f7 == 0 || f7 == 7'h20)) return 2;
    if (op == 7'h33 && f7 != 0 && !(f7 == 7'h20 && (f3 == 0 || f3 == 5))) return 2;
`ifdef RV32I_ENC_IMM_CHECK_EN
    case (op)
      7'h37, 7'h17: if ((imm & 32'hFFF) != 0) return 3;
      7'h6F: if (s < -(1 << 20) || s > (1 << 20) - 2 || s % 2 != 0) return 3;
      7'h63: if (s < -4096 || s > 4094 || s % 2 != 0) return 3;
      7'h67, 7'h03, 7'h23: if (s < -2048 || s > 2047) return 3;
      7'h13: if (f3 == 1 || f3 == 5) begin
               if (s < 0 || s > 31) return 3;
             end else if (s < -2048 || s > 2047) return 3;
      default: ;
    endcase
`endif
    return 0;
  endfunction

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_valid = 1'b1;
    bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
    bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
  endtask

  // Holds the bundle until accepted (bounded); returns just after the accept edge.
  task automatic accept(input string tag);
    int n;
    n = 0;
    #1;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    cyc();
    bus.in_valid = 1'b0;
  endtask

  // One legal bundle through an empty pipe with out_ready=1.
  task automatic one(input string tag, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] exp);
    bus.out_ready = 1'b1;
    set_in(op, f3, f7, rd, rs1, rs2, imm);
    accept(tag);
    #1;
    chk({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
    cyc(); #1;
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_instr"}, bus.out_instr, exp);
    cyc(); #1;
    chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    cyc(); cyc();
    nrst = 1'b1;
  endtask

  initial begin
    int acc;
    int n;
    int c;
    logic iv;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm;

    nrst = 1'b0;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
    bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;

    // ---- reset state ----
    apply_reset();
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
    chk("rst_err_cause", 32'(bus.err_cause), 32'd0);
    chk("rst_err_count", 32'(bus.err_count), 32'd0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // ---- directed formats ----
    one("addi", 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093);
    one("beq", 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h00208463);
    one("jal", 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h001000EF);
    one("sw", 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE20AE23);

    // ---- backpressure: 6 offered, 5 accepted ----
    bus.out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      set_in(7'h13, 3'd0, 7'd0, 5'(acc), 5'd0, 5'd0, 32'(acc + 100));
      #1;
      if (bus.in_ready) acc++;
      cyc();
    end
    bus.in_valid = 1'b0;
    #1;
    chk("bp_accepted", 32'(acc), 32'd5);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_fifo_count", 32'(bus.fifo_count), 32'd4);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_drain_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_drain_instr", bus.out_instr,
          ref_enc(7'h13, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 32'(k + 100)));
      cyc();
    end
    #1;
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // ---- error reporting ----
    set_in(7'h7F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    accept("bad_op");
    #1;
    chk("bad_op_pulse", 32'(bus.err_pulse), 32'd1);
    chk("bad_op_no_out", 32'(bus.out_valid), 32'd0);
    cyc(); #1;
    chk("bad_op_pulse_end", 32'(bus.err_pulse), 32'd0);
    chk("bad_op_cause", 32'(bus.err_cause), 32'd1);
    chk("bad_op_count", 32'(bus.err_count), 32'd1);
    chk("bad_op_still_no_out", 32'(bus.out_valid), 32'd0);
    set_in(7'h03, 3'd3, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    accept("bad_ld");
    cyc(); #1;
    chk("bad_ld_cause", 32'(bus.err_cause), 32'd2);
    chk("bad_ld_count", 32'(bus.err_count), 32'd2);
    set_in(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    n = 0;
    for (int k = 0; k < 400 && n < 300; k++) begin
      #1;
      if (bus.in_ready) n++;
      cyc();
    end
    bus.in_valid = 1'b0;
    cyc(); cyc(); #1;
    chk("sat_accepted", 32'(n), 32'd300);
    chk("sat_count", 32'(bus.err_count), 32'd255);

    // ---- flush ----
    set_in(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    accept("flush_bad");
    bus.flush = 1'b1;
    #1;
    chk("flush_no_pulse", 32'(bus.err_pulse), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_in(7'h13, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 32'(k));
      accept("flush_fill");
    end
    cyc(); #1;
    chk("flush_fill_count", 32'(bus.fifo_count), 32'd3);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    #1;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("flush_err_count", 32'(bus.err_count), 32'd255);
    chk("flush_err_cause", 32'(bus.err_cause), 32'd1);
    for (int k = 0; k < 3; k++) begin
      set_in(7'h13, 3'd0, 7'd0, 5'(k), 5'd0, 5'd0, 32'(k));
      accept("rst_fill");
    end
    nrst = 1'b0;
    cyc();
    nrst = 1'b1;
    #1;
    chk("rst_mid_err_count", 32'(bus.err_count), 32'd0);
    chk("rst_mid_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);

    // ---- out-of-range immediate ----
`ifdef RV32I_ENC_IMM_CHECK_EN
    bus.out_ready = 1'b1;
    set_in(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
    accept("imm_range");
    #1;
    chk("imm_range_pulse", 32'(bus.err_pulse), 32'd1);
    cyc(); #1;
    chk("imm_range_cause", 32'(bus.err_cause), 32'd3);
    chk("imm_range_no_out", 32'(bus.out_valid), 32'd0);
`else
    one("imm_trunc", 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 32'h00000093);
`endif

    // ---- randomized traffic against the reference model ----
    apply_reset();
    begin
      int m_err;
      int m_cause;
      m_err = 0;
      m_cause = 0;
      exp_q.delete();
      for (int cy = 0; cy < 1500; cy++) begin
        iv  = ($urandom_range(0, 9) < 7);
        op  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
        f3  = 3'($urandom);
        case ($urandom_range(0, 2))
          0: f7 = 7'd0;
          1: f7 = 7'h20;
          default: f7 = 7'($urandom);
        endcase
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        case ($urandom_range(0, 3))
          0: imm = 32'($signed($urandom_range(0, 80)) - 40);
          1: imm = $urandom;
          2: begin
            logic [31:0] edges [8];
            edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049,
                      32'd4094, 32'd4096, 32'd31, 32'd32};
            imm = edges[$urandom_range(0, 7)];
          end
          default: imm = 32'($signed($urandom_range(0, 32'h1FFFFF)) - 32'h100000);
        endcase
        if (iv) set_in(op, f3, f7, rd, rs1, rs2, imm);
        else bus.in_valid = 1'b0;
        bus.out_ready = ($urandom_range(0, 9) < 6);
        #1;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            assert (exp_q.size() != 0) else begin
              errors++;
              $error("FAIL rnd_spurious_out: observed word 0x%08h expected no word", bus.out_instr);
            end
          end else begin
            chk("rnd_out", bus.out_instr, exp_q.pop_front());
          end
        end
        if (iv && bus.in_ready) begin
          c = ref_cause(op, f3, f7, imm);
          if (c == 0) exp_q.push_back(ref_enc(op, f3, f7, rd, rs1, rs2, imm));
          else begin
            if (m_err < 255) m_err++;
            m_cause = c;
          end
        end
        cyc();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 30; k++) begin
        #1;
        if (bus.out_valid && exp_q.size() != 0) chk("rnd_drain", bus.out_instr, exp_q.pop_front());
        cyc();
      end
      #1;
      chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("rnd_out_valid_end", 32'(bus.out_valid), 32'd0);
      chk("rnd_err_count", 32'(bus.err_count), 32'(m_err));
      chk("rnd_err_cause", 32'(bus.err_cause), 32'(m_cause));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
